// File: rtl/pixel_filter_buffer.sv
// pixel_filter_buffer
//
// Single-clock dual-port frame buffer with a two-stage read pipeline and a
// colour filter on the read path. The camera capture logic writes pixels and
// the VGA fetch logic reads them. The filter mode and threshold only change
// on a frame_start pulse, so one frame never mixes two filters.
//
// Ports:
//   clk          single clock for write, read and filter logic
//   reset        synchronous, active-high; flushes the read pipeline and
//                the filter settings, RAM contents are kept
//   wr_en        write strobe
//   wr_addr      write address; addresses >= DEPTH are ignored
//   wr_data      packed {R,G,B} pixel to store
//   rd_en        read request
//   rd_addr      read address; addresses >= DEPTH read as zero
//   rd_valid     rd_data holds a filtered pixel (2 cycles after rd_en)
//   rd_data      filtered pixel
//   mode_req     requested filter mode, taken on frame_start
//   thr_req      requested threshold for mode 6, taken on frame_start
//   frame_start  one-cycle pulse that loads mode_req/thr_req
//   active_mode  filter currently applied in stage 2

module pixel_filter_buffer #(
    parameter int AW    = 15,
    parameter int DEPTH = 19200,
    parameter int CW    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [3*CW-1:0]   wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic              rd_valid,
    output logic [3*CW-1:0]   rd_data,
    input  logic [2:0]        mode_req,
    input  logic [CW-1:0]     thr_req,
    input  logic              frame_start,
    output logic [2:0]        active_mode
);

    localparam int DW = 3 * CW;

    // One extra bit so DEPTH itself is representable for the range checks.
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [DW-1:0] ram [0:DEPTH-1];

    logic          wr_in_range;
    logic          rd_in_range;

    logic [DW-1:0] raw;
    logic          v1;
    logic [CW-1:0] thr;

    logic [CW-1:0] r, g, b, y;
    logic [CW+1:0] luma_sum;
    logic [DW-1:0] filtered;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);

    // Frame storage. Not reset so a pipeline reset never loses the frame.
    always_ff @(posedge clk) begin
        if (!reset && wr_en && wr_in_range) begin
            ram[wr_addr] <= wr_data;
        end
    end

    // Stage 1: registered RAM read. Because the write above is also
    // non-blocking, a same-address write in this cycle is not yet visible,
    // giving read-first collision behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            raw <= '0;
            v1  <= 1'b0;
        end else begin
            v1 <= rd_en;
            if (rd_en) begin
                raw <= rd_in_range ? ram[rd_addr] : '0;
            end
        end
    end

    // Luma approximation (r + 2g + b) / 4, two guard bits avoid overflow.
    always_comb begin
        r        = raw[3*CW-1:2*CW];
        g        = raw[2*CW-1:CW];
        b        = raw[CW-1:0];
        luma_sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        y        = luma_sum[CW+1:2];
        filtered = raw;
        case (active_mode)
            3'd1:    filtered = ~raw;
            3'd2:    filtered = {r, {CW{1'b0}}, {CW{1'b0}}};
            3'd3:    filtered = {{CW{1'b0}}, g, {CW{1'b0}}};
            3'd4:    filtered = {{CW{1'b0}}, {CW{1'b0}}, b};
            3'd5:    filtered = {y, y, y};
            3'd6:    filtered = (y >= thr) ? {DW{1'b1}} : {DW{1'b0}};
            default: filtered = raw;
        endcase
    end

    // Stage 2 plus the mode latch. The filter evaluated at a frame_start
    // edge still sees the previous mode/threshold.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            active_mode <= 3'd0;
            thr         <= '0;
        end else begin
            rd_valid <= v1;
            rd_data  <= filtered;
            if (frame_start) begin
                active_mode <= mode_req;
                thr         <= thr_req;
            end
        end
    end

endmodule

// File: tb/tb_pixel_filter_buffer.sv
// tb_pixel_filter_buffer
//
// Self-checking bench for pixel_filter_buffer with CW=4 (12-bit pixels).
// A directed table covers pass-through, the mode sweep, grey/threshold,
// address boundaries, read/write collision and reset behaviour, then a
// randomized phase is compared against a behavioural reference model.
//
// Ports: none (top-level testbench).

module tb_pixel_filter_buffer;

    localparam int AW    = 15;
    localparam int DEPTH = 19200;
    localparam int CW    = 4;
    localparam int DW    = 3 * CW;
    localparam int ALL1  = (1 << DW) - 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [2:0]    mode_req;
    logic [CW-1:0] thr_req;
    logic          frame_start;
    logic [2:0]    active_mode;

    pixel_filter_buffer #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .mode_req    (mode_req),
        .thr_req     (thr_req),
        .frame_start (frame_start),
        .active_mode (active_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of inputs plus the outputs expected after the following edge.
    typedef struct {
        int rst; int we; int wa; int wd; int re; int ra;
        int fs;  int md; int th;
        int ev;  int cd; int ed; int em;
    } vec_t;

    vec_t vecs[30];

    int checks;
    int passed;

    // Reference model state: known RAM contents, the pending request,
    // the filter settings in force, and the expected outputs.
    int mem [int];
    int m_mode;
    int m_thr;
    bit h_valid;
    bit h_known;
    int h_pix;
    bit e_valid;
    bit e_chk;
    int e_data;
    bit model_live;

    function automatic vec_t mk(int rst, int we, int wa, int wd, int re, int ra,
                                int fs, int md, int th,
                                int ev, int cd, int ed, int em);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
        v.fs = fs; v.md = md; v.th = th;
        v.ev = ev; v.cd = cd; v.ed = ed; v.em = em;
        return v;
    endfunction

    // Filter rules written with plain integer arithmetic.
    function automatic int filt(int p, int md, int th);
        int rc, gc, bc, yv;
        rc = (p >> (2 * CW)) & CMAX;
        gc = (p >> CW) & CMAX;
        bc = p & CMAX;
        yv = (rc + 2 * gc + bc) / 4;
        case (md)
            1:       return ALL1 - p;
            2:       return rc * (1 << (2 * CW));
            3:       return gc * (1 << CW);
            4:       return bc;
            5:       return yv * (1 + (1 << CW) + (1 << (2 * CW)));
            6:       return (yv >= th) ? ALL1 : 0;
            default: return p;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic modelEdge();
        int a;
        if (reset) begin
            h_valid    = 0;
            m_mode     = 0;
            m_thr      = 0;
            e_valid    = 0;
            e_data     = 0;
            e_chk      = 1;
            model_live = 1;
        end else begin
            e_valid = h_valid;
            e_chk   = h_valid && h_known;
            if (h_valid) e_data = filt(h_pix, m_mode, m_thr);
            if (frame_start) begin
                m_mode = int'(mode_req);
                m_thr  = int'(thr_req);
            end
            h_valid = rd_en;
            if (rd_en) begin
                a = int'(rd_addr);
                if (a >= DEPTH) begin
                    h_pix = 0; h_known = 1;
                end else if (mem.exists(a)) begin
                    h_pix = mem[a]; h_known = 1;
                end else begin
                    h_known = 0;
                end
            end
            if (wr_en && int'(wr_addr) < DEPTH) mem[int'(wr_addr)] = int'(wr_data);
        end
    endtask

    // Drive one cycle of inputs, clock it, and stop mid-cycle for sampling.
    task automatic applyStimulus(input vec_t v);
        reset       = v.rst[0];
        wr_en       = v.we[0];
        wr_addr     = AW'(v.wa);
        wr_data     = DW'(v.wd);
        rd_en       = v.re[0];
        rd_addr     = AW'(v.ra);
        frame_start = v.fs[0];
        mode_req    = 3'(v.md);
        thr_req     = CW'(v.th);
        modelEdge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput();
        if (model_live) begin
            check("model rd_valid", int'(rd_valid), int'(e_valid));
            if (e_chk) check("model rd_data", int'(rd_data), e_data);
            check("model active_mode", int'(active_mode), m_mode);
        end
    endtask

    initial begin
        checks = 0; passed = 0; model_live = 0;
        m_mode = 0; m_thr = 0; h_valid = 0; h_known = 0; h_pix = 0;
        e_valid = 0; e_chk = 0; e_data = 0;

        //             rst we wa      wd      re ra     fs md th  ev cd ed      em
        vecs[0]  = mk(1, 0, 0,     0,      0, 0,     0, 0, 0,  0, 1, 0,      0);
        vecs[1]  = mk(0, 1, 10,    'hF0F,  0, 0,     0, 0, 0,  0, 0, 0,      0);
        vecs[2]  = mk(0, 1, 11,    'h0F0,  1, 10,    0, 0, 0,  0, 0, 0,      0);
        vecs[3]  = mk(0, 0, 0,     0,      1, 11,    0, 0, 0,  1, 1, 'hF0F,  0);
        vecs[4]  = mk(0, 1, 5,     'hF00,  0, 0,     0, 0, 0,  1, 1, 'h0F0,  0);
        vecs[5]  = mk(0, 1, 5,     'h0FF,  1, 5,     0, 0, 0,  0, 0, 0,      0);
        vecs[6]  = mk(0, 0, 0,     0,      1, 5,     0, 0, 0,  1, 1, 'hF00,  0);
        vecs[7]  = mk(0, 0, 0,     0,      0, 0,     0, 0, 0,  1, 1, 'h0FF,  0);
        vecs[8]  = mk(0, 0, 0,     0,      0, 0,     0, 0, 0,  0, 0, 0,      0);
        vecs[9]  = mk(0, 1, 19199, 'hABC,  0, 0,     0, 0, 0,  0, 0, 0,      0);
        vecs[10] = mk(0, 1, 19200, 'hFFF,  1, 19200, 0, 0, 0,  0, 0, 0,      0);
        vecs[11] = mk(0, 0, 0,     0,      1, 19199, 0, 0, 0,  1, 1, 'h000,  0);
        vecs[12] = mk(0, 0, 0,     0,      0, 0,     0, 0, 0,  1, 1, 'hABC,  0);
        vecs[13] = mk(0, 1, 20,    'hFF0,  0, 0,     0, 0, 0,  0, 0, 0,      0);
        vecs[14] = mk(0, 0, 0,     0,      1, 20,    1, 1, 0,  0, 0, 0,      1);
        vecs[15] = mk(0, 0, 0,     0,      1, 20,    1, 2, 0,  1, 1, 'h00F,  2);
        vecs[16] = mk(0, 0, 0,     0,      1, 20,    1, 3, 0,  1, 1, 'hF00,  3);
        vecs[17] = mk(0, 0, 0,     0,      1, 20,    1, 4, 0,  1, 1, 'h0F0,  4);
        vecs[18] = mk(0, 0, 0,     0,      0, 0,     0, 0, 0,  1, 1, 'h000,  4);
        vecs[19] = mk(0, 0, 0,     0,      0, 0,     0, 0, 0,  0, 0, 0,      4);
        vecs[20] = mk(0, 0, 0,     0,      1, 20,    1, 5, 0,  0, 0, 0,      5);
        vecs[21] = mk(0, 0, 0,     0,      1, 20,    1, 6, 12, 1, 1, 'hBBB,  6);
        vecs[22] = mk(0, 0, 0,     0,      1, 20,    1, 6, 11, 1, 1, 'h000,  6);
        vecs[23] = mk(0, 0, 0,     0,      0, 0,     0, 0, 0,  1, 1, 'hFFF,  6);
        vecs[24] = mk(0, 0, 0,     0,      1, 10,    1, 1, 0,  0, 0, 0,      1);
        vecs[25] = mk(0, 0, 0,     0,      1, 10,    0, 0, 0,  1, 1, 'h0F0,  1);
        vecs[26] = mk(1, 0, 0,     0,      1, 10,    0, 0, 0,  0, 1, 0,      0);
        vecs[27] = mk(0, 0, 0,     0,      1, 10,    0, 0, 0,  0, 0, 0,      0);
        vecs[28] = mk(0, 0, 0,     0,      0, 0,     0, 0, 0,  1, 1, 'hF0F,  0);
        vecs[29] = mk(1, 0, 0,     0,      0, 0,     1, 3, 5,  0, 1, 0,      0);

        $display("[TB] directed table");
        for (int i = 0; i < 30; i++) begin
            applyStimulus(vecs[i]);
            check($sformatf("row%0d rd_valid", i), int'(rd_valid), vecs[i].ev);
            if (vecs[i].cd != 0) check($sformatf("row%0d rd_data", i), int'(rd_data), vecs[i].ed);
            check($sformatf("row%0d active_mode", i), int'(active_mode), vecs[i].em);
            checkOutput();
        end

        $display("[TB] randomized phase");
        for (int i = 0; i < 3000; i++) begin
            vec_t v;
            int sel;
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            v.rst = ($urandom_range(0, 99) == 0) ? 1 : 0;
            v.we  = int'($urandom_range(0, 1));
            v.re  = ($urandom_range(0, 9) < 7) ? 1 : 0;
            v.fs  = ($urandom_range(0, 9) == 0) ? 1 : 0;
            v.md  = int'($urandom_range(0, 7));
            v.th  = int'($urandom_range(0, CMAX));
            v.wd  = int'($urandom_range(0, ALL1));
            sel   = int'($urandom_range(0, 3));
            v.wa  = (sel == 0) ? DEPTH - 3 + int'($urandom_range(0, 6)) : int'($urandom_range(0, 31));
            sel   = int'($urandom_range(0, 3));
            v.ra  = (sel == 0) ? DEPTH - 3 + int'($urandom_range(0, 6)) : int'($urandom_range(0, 31));
            applyStimulus(v);
            checkOutput();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pixel_filter_buffer.md
# pixel_filter_buffer

Single-clock dual-port frame buffer with a pipelined, parametrised colour-filter stage on the read path. It sits between the camera capture FSM (write side) and the VGA pixel fetch logic (read side). It stores packed RGB pixels of configurable channel width and depth. The filter mode and threshold are latched only at frame boundaries, so a frame is never displayed with mixed filters.

## Interface
Parameters:
- AW, 15, address width
- DEPTH, 19200, number of valid pixel locations (≤ 2**AW); e.g. 160x120
- CW, 1, bits per colour channel; pixel width DW = 3*CW, packed {R,G,B}, R in MSBs

Ports:
- clk  input  1  single clock for write, read and filter logic
- reset  input  1  synchronous, active-high
- wr_en  input  1  write strobe
- wr_addr  input  AW  write address
- wr_data  input  3*CW  pixel to store
- rd_en  input  1  read request
- rd_addr  input  AW  read address
- rd_valid  output  1  rd_data holds a filtered pixel
- rd_data  output  3*CW  filtered pixel
- mode_req  input  3  requested filter mode
- thr_req  input  CW  requested threshold for mode 6
- frame_start  input  1  one-cycle pulse; loads mode_req/thr_req into the active registers
- active_mode  output  3  filter currently applied

## Operation
- Memory: DEPTH words of DW bits, not reset, contents undefined after power-up.
- Write: on a rising clk edge with wr_en=1, reset=0 and wr_addr < DEPTH, ram[wr_addr] <= wr_data. Writes with wr_addr ≥ DEPTH are dropped silently. Writes are suppressed while reset=1.
- Read stage 1: when rd_en=1, the RAM word is registered into raw, and v1 <= 1. An address ≥ DEPTH yields raw = 0, still valid. When rd_en=0, v1 <= 0.
- Read/write collision, same address in the same cycle: the read returns the old contents (read-first).
- Stage 2: rd_data <= f(raw, active_mode, thr); rd_valid <= v1. With r, g, b each CW bits:
  - 0: pass {r,g,b}
  - 1: invert {~r,~g,~b}
  - 2: red only {r,0,0}
  - 3: green only {0,g,0}
  - 4: blue only {0,0,b}
  - 5: grey. y = (r + 2g + b) >> 2, computed at CW+2 bits so there is no overflow. Output {y,y,y}.
  - 6: threshold. Output all-ones when y ≥ thr, else all-zeros.
  - 7: pass (same as 0)
- Mode latch: on an edge with frame_start=1, active_mode <= mode_req and thr <= thr_req. Stage 2 evaluated at that same edge still uses the old values. The mode applies to whatever pixel is in stage 2, not to the pixel's request time.

## Timing
- Read latency: 2 cycles. A request at edge N gives rd_valid=1 with data after edge N+2.
- Full throughput: one read and one write per cycle, with no stalls and no backpressure.
- rd_valid follows rd_en delayed by 2 cycles, with no bubbles inserted.
- Reset values: rd_valid=0, rd_data=0, active_mode=0, thr=0, v1=0, raw=0.
- Reset mid-operation: the pipeline is flushed. rd_valid is 0 on the cycle after the reset edge and stays 0 until 2 cycles after the first post-reset rd_en. RAM contents are preserved.
- If frame_start and reset are asserted together, reset wins and the mode becomes 0.
- Write-then-read of the same address: a read issued ≥1 cycle after the write returns the new data.

## Test plan
- Pass-through, CW=1: write 3'b101 to address 10, read it at cycle +1 -> rd_valid=1 two cycles later with rd_data=3'b101. Reading address 11, previously written 3'b010, back-to-back gives consecutive valid outputs.
- Mode sweep: mode_req=1..4 with frame_start pulses, reading 3'b110 -> outputs 001, 100, 010, 000 respectively. mode_req=3 on 3'b110 gives 010, and active_mode tracks each change.
- Grey/threshold, CW=4: pixel {15,15,0}, mode 5 -> y=(15+30+0)>>2=11, rd_data={11,11,11}. Mode 6 with thr=12 -> all zeros; with thr=11 -> 12'hFFF.
- Boundary: write 3'b111 to address DEPTH (19200) -> no RAM change. A read of address 19200 returns 0 with rd_valid=1. Address DEPTH-1 writes and reads normally.
- Collision: the same cycle writes 3'b011 and reads address 5, which held 3'b100 -> read returns 3'b100. The next read returns 3'b011.
- Reset mid-stream: continuous reads in mode 1, then assert reset for 1 cycle -> rd_valid=0, rd_data=0, active_mode=0. Earlier RAM writes are intact after reset, and the first post-reset read is valid 2 cycles later.
